// File: rtl/pipelined_cla_adder_pkg.sv
// Shared constants and the pipeline stage-register type for the pipelined CLA adder.
package pipelined_cla_adder_pkg;

    localparam int DEF_WIDTH  = 32;
    localparam int DEF_STAGES = 4;
    // Stage registers are sized for the widest supported operand; narrower builds zero the top bits.
    localparam int MAX_WIDTH  = 64;

    typedef struct packed {
        logic                 vld;
        logic                 sub;
        logic                 carry;
        logic [MAX_WIDTH-1:0] sum;
        logic [MAX_WIDTH-1:0] a;
        logic [MAX_WIDTH-1:0] b;
    } stage_t;

endpackage

// File: rtl/pipelined_cla_adder_if.sv
// Operand/result valid-ready bus of the pipelined CLA adder.
interface pipelined_cla_adder_if
    import pipelined_cla_adder_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_a;
    logic [WIDTH-1:0] in_b;
    logic             in_cin;
    logic             in_sub;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_sum;
    logic             out_cout;
    logic             out_ovf;
    logic             out_zero;
    logic             out_neg;

    modport master (
        output in_valid, in_a, in_b, in_cin, in_sub, out_ready,
        input  in_ready, out_valid, out_sum, out_cout, out_ovf, out_zero, out_neg
    );

    modport slave (
        input  in_valid, in_a, in_b, in_cin, in_sub, out_ready,
        output in_ready, out_valid, out_sum, out_cout, out_ovf, out_zero, out_neg
    );
endinterface

// File: rtl/pipelined_cla_adder_cla_slice.sv
// W-bit adder slice: 4-bit generate/propagate lookahead groups, carry rippled between groups.
module cla_slice #(
    parameter int W = 8
) (
    input  logic [W-1:0] a_i,
    input  logic [W-1:0] b_i,
    input  logic         cin_i,
    output logic [W-1:0] sum_o,
    output logic         cout_o,
    output logic         cmsb_o
);
    logic [3:0] g;
    logic [3:0] p;
    logic [4:0] c;
    logic       cy;

    always_comb begin
        sum_o = '0;
        g     = '0;
        p     = '0;
        c     = '0;
        cy    = cin_i;
        for (int grp = 0; grp < W / 4; grp++) begin
            g    = a_i[grp*4 +: 4] & b_i[grp*4 +: 4];
            p    = a_i[grp*4 +: 4] | b_i[grp*4 +: 4];
            c[0] = cy;
            c[1] = g[0] | (p[0] & cy);
            c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & cy);
            c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & cy);
            c[4] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0])
                 | (p[3] & p[2] & p[1] & p[0] & cy);
            sum_o[grp*4 +: 4] = a_i[grp*4 +: 4] ^ b_i[grp*4 +: 4] ^ c[3:0];
            cy = c[4];
        end
        cmsb_o = c[3];
        cout_o = cy;
    end
endmodule

// File: rtl/pipelined_cla_adder.sv
// Valid/ready pipelined adder/subtractor: one SLICE of the sum per stage, flags registered at the output.
module pipelined_cla_adder
    import pipelined_cla_adder_pkg::*;
#(
    parameter int WIDTH  = DEF_WIDTH,
    parameter int STAGES = DEF_STAGES
) (
    input  logic                  clk,
    input  logic                  rst,
    pipelined_cla_adder_if.slave  bus
);
    localparam int SLICE = WIDTH / STAGES;
    localparam int LAST  = STAGES - 1;

    if ((STAGES < 1) || (WIDTH % STAGES != 0) || (SLICE % 4 != 0) || (SLICE == 0)
        || (WIDTH > MAX_WIDTH)) begin : g_cfg_err
        $error("pipelined_cla_adder: WIDTH must split into STAGES slices of a multiple of 4 bits");
    end

    stage_t [STAGES-1:0]            st_q, st_d;
    logic   [STAGES-1:0][SLICE-1:0] sl_a, sl_b, sl_s;
    logic   [STAGES-1:0]            sl_cin, sl_cout, sl_cmsb;

    logic             out_valid_q, out_cout_q, out_ovf_q, out_zero_q, out_neg_q;
    logic [WIDTH-1:0] out_sum_q;
    logic [WIDTH-1:0] fin_sum;
    logic [MAX_WIDTH-1:0] a_ext, b_ext;
    logic             en;

    assign en           = !out_valid_q || bus.out_ready;
    assign bus.in_ready = en && !rst;

    for (genvar k = 0; k < STAGES; k++) begin : g_stage
        assign sl_a[k]   = st_q[k].a[k*SLICE +: SLICE];
        assign sl_b[k]   = st_q[k].b[k*SLICE +: SLICE];
        assign sl_cin[k] = st_q[k].carry;

        cla_slice #(.W(SLICE)) u_slice (
            .a_i    (sl_a[k]),
            .b_i    (sl_b[k]),
            .cin_i  (sl_cin[k]),
            .sum_o  (sl_s[k]),
            .cout_o (sl_cout[k]),
            .cmsb_o (sl_cmsb[k])
        );
    end

    // Subtract is folded into the capture stage: b is inverted and the carry forced to 1.
    always_comb begin
        a_ext              = '0;
        b_ext              = '0;
        a_ext[WIDTH-1:0]   = bus.in_a;
        b_ext[WIDTH-1:0]   = bus.in_sub ? ~bus.in_b : bus.in_b;
        st_d               = st_q;
        st_d[0].vld        = bus.in_valid;
        st_d[0].sub        = bus.in_sub;
        st_d[0].carry      = bus.in_sub ? 1'b1 : bus.in_cin;
        st_d[0].sum        = '0;
        st_d[0].a          = a_ext;
        st_d[0].b          = b_ext;
        for (int k = 0; k < LAST; k++) begin
            st_d[k+1]                      = st_q[k];
            st_d[k+1].sum[k*SLICE +: SLICE] = sl_s[k];
            st_d[k+1].carry                = sl_cout[k];
        end
    end

    always_comb begin
        fin_sum                      = st_q[LAST].sum[WIDTH-1:0];
        fin_sum[LAST*SLICE +: SLICE] = sl_s[LAST];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int k = 0; k < STAGES; k++) st_q[k].vld <= 1'b0;
            out_valid_q <= 1'b0;
            out_sum_q   <= '0;
            out_cout_q  <= 1'b0;
            out_ovf_q   <= 1'b0;
            out_zero_q  <= 1'b0;
            out_neg_q   <= 1'b0;
        end else if (en) begin
            st_q        <= st_d;
            out_valid_q <= st_q[LAST].vld;
            out_sum_q   <= fin_sum;
            out_cout_q  <= sl_cout[LAST];
            out_ovf_q   <= sl_cmsb[LAST] ^ sl_cout[LAST];
            out_zero_q  <= (fin_sum == '0);
            out_neg_q   <= fin_sum[WIDTH-1];
        end
    end

    assign bus.out_valid = out_valid_q;
    assign bus.out_sum   = out_sum_q;
    assign bus.out_cout  = out_cout_q;
    assign bus.out_ovf   = out_ovf_q;
    assign bus.out_zero  = out_zero_q;
    assign bus.out_neg   = out_neg_q;

    // Consumed operand bits, unused upper bits and the travelling sub flag feed no logic.
    logic unused_bits;
    assign unused_bits = ^{st_q, sl_cmsb};
endmodule

// File: tb/tb_pipelined_cla_adder.sv
// Directed bench: 32-bit/4-stage and 8-bit/1-stage adders with hand-computed results.
module tb_pipelined_cla_adder;
    logic clk = 1'b0;
    logic rst;
    int   n_vec = 0;
    int   n_err = 0;

    always #5 clk = ~clk;

    pipelined_cla_adder_if #(.WIDTH(32)) bus ();
    pipelined_cla_adder_if #(.WIDTH(8))  bus8 ();

    pipelined_cla_adder #(.WIDTH(32), .STAGES(4)) u_dut (.clk(clk), .rst(rst), .bus(bus));
    pipelined_cla_adder #(.WIDTH(8),  .STAGES(1)) u_dut8 (.clk(clk), .rst(rst), .bus(bus8));

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        bus.in_valid = 0; bus.in_a = '0; bus.in_b = '0; bus.in_cin = 0; bus.in_sub = 0;
        bus.out_ready = 1;
        bus8.in_valid = 0; bus8.in_a = '0; bus8.in_b = '0; bus8.in_cin = 0; bus8.in_sub = 0;
        bus8.out_ready = 1;
        tick();
        tick();
        n_vec++;
        if ({bus.out_valid, bus.out_sum, bus.out_cout, bus.out_ovf, bus.out_zero, bus.out_neg} !== 37'd0) begin
            n_err++;
            $display("FAIL reset_out: got v=%b sum=%h flags=%b%b%b%b expected all zero",
                     bus.out_valid, bus.out_sum, bus.out_cout, bus.out_ovf, bus.out_zero, bus.out_neg);
        end
        n_vec++;
        if (bus.in_ready !== 1'b0) begin
            n_err++;
            $display("FAIL reset_in_ready: got %b expected 0", bus.in_ready);
        end
        n_vec++;
        if ({bus8.out_valid, bus8.out_sum} !== 9'd0) begin
            n_err++;
            $display("FAIL reset_out8: got v=%b sum=%h expected 0", bus8.out_valid, bus8.out_sum);
        end
        rst = 1'b0;
        #1;
        n_vec++;
        if (bus.in_ready !== 1'b1) begin
            n_err++;
            $display("FAIL release_in_ready: got %b expected 1", bus.in_ready);
        end
    endtask

    task automatic test_add();
        logic [31:0] va [3] = '{32'hFFFF_FFFF, 32'h7FFF_FFFF, 32'h1234_5678};
        logic [31:0] vb [3] = '{32'h0000_0001, 32'h0000_0001, 32'h0F0F_0F0F};
        logic        vc [3] = '{1'b0, 1'b0, 1'b1};
        logic [31:0] es [3] = '{32'h0000_0000, 32'h8000_0000, 32'h2143_6588};
        logic [3:0]  ef [3] = '{4'b1010, 4'b0101, 4'b0000};
        for (int i = 0; i < 3; i++) begin
            tick();
            bus.in_valid = 1; bus.in_a = va[i]; bus.in_b = vb[i]; bus.in_cin = vc[i]; bus.in_sub = 0;
            #1;
            n_vec++;
            if (bus.in_ready !== 1'b1) begin
                n_err++;
                $display("FAIL add%0d_in_ready: got %b expected 1", i, bus.in_ready);
            end
            tick();
            bus.in_valid = 0;
            repeat (3) tick();
            n_vec++;
            if (bus.out_valid !== 1'b0) begin
                n_err++;
                $display("FAIL add%0d_early: out_valid got %b expected 0 after 3 cycles", i, bus.out_valid);
            end
            tick();
            n_vec++;
            if (bus.out_valid !== 1'b1 || bus.out_sum !== es[i]) begin
                n_err++;
                $display("FAIL add%0d_sum: got v=%b %h expected v=1 %h", i, bus.out_valid, bus.out_sum, es[i]);
            end
            n_vec++;
            if ({bus.out_cout, bus.out_ovf, bus.out_zero, bus.out_neg} !== ef[i]) begin
                n_err++;
                $display("FAIL add%0d_flags: got %b%b%b%b expected %b", i,
                         bus.out_cout, bus.out_ovf, bus.out_zero, bus.out_neg, ef[i]);
            end
        end
        tick();
    endtask

    task automatic test_sub();
        logic [31:0] va [3] = '{32'd5, 32'd7, 32'd7};
        logic [31:0] vb [3] = '{32'd7, 32'd5, 32'd7};
        logic        vc [3] = '{1'b0, 1'b0, 1'b1};
        logic [31:0] es [3] = '{32'hFFFF_FFFE, 32'h0000_0002, 32'h0000_0000};
        logic [3:0]  ef [3] = '{4'b0001, 4'b1000, 4'b1010};
        for (int i = 0; i < 3; i++) begin
            bus.in_valid = 1; bus.in_a = va[i]; bus.in_b = vb[i]; bus.in_cin = vc[i]; bus.in_sub = 1;
            tick();
            bus.in_valid = 0;
            repeat (4) tick();
            n_vec++;
            if (bus.out_valid !== 1'b1 || bus.out_sum !== es[i]) begin
                n_err++;
                $display("FAIL sub%0d_sum: got v=%b %h expected v=1 %h", i, bus.out_valid, bus.out_sum, es[i]);
            end
            n_vec++;
            if ({bus.out_cout, bus.out_ovf, bus.out_zero, bus.out_neg} !== ef[i]) begin
                n_err++;
                $display("FAIL sub%0d_flags: got %b%b%b%b expected %b", i,
                         bus.out_cout, bus.out_ovf, bus.out_zero, bus.out_neg, ef[i]);
            end
            tick();
        end
    endtask

    task automatic test_back_to_back();
        logic [31:0] va [8] = '{32'd1, 32'h10, 32'hFFFF_0000, 32'd100,
                                32'hA5A5_A5A5, 32'h8000_0000, 32'h0000_1000, 32'd0};
        logic [31:0] vb [8] = '{32'd2, 32'h20, 32'h0001_0000, 32'd1,
                                32'h5A5A_5A5A, 32'd1, 32'h0000_0234, 32'd1};
        logic        vs [8] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
        logic        vc [8] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
        logic [31:0] es [8] = '{32'd3, 32'h30, 32'h0, 32'h63,
                                32'h0, 32'h7FFF_FFFF, 32'h0000_1234, 32'hFFFF_FFFF};
        logic        ec [8] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
        int nin = 0;
        int nout = 0;
        int cyc = 0;
        while (nout < 8 && cyc < 40) begin
            bus.out_ready = !(cyc >= 6 && cyc <= 8);
            if (nin < 8) begin
                bus.in_valid = 1; bus.in_a = va[nin]; bus.in_b = vb[nin];
                bus.in_cin = vc[nin]; bus.in_sub = vs[nin];
            end else begin
                bus.in_valid = 0;
            end
            #1;
            if (cyc >= 6 && cyc <= 8) begin
                n_vec++;
                if (bus.in_ready !== 1'b0) begin
                    n_err++;
                    $display("FAIL stall_in_ready cyc%0d: got %b expected 0", cyc, bus.in_ready);
                end
                n_vec++;
                if (bus.out_valid !== 1'b1 || bus.out_sum !== es[nout]) begin
                    n_err++;
                    $display("FAIL stall_hold cyc%0d: got v=%b %h expected v=1 %h",
                             cyc, bus.out_valid, bus.out_sum, es[nout]);
                end
            end
            if (bus.out_valid === 1'b1 && bus.out_ready) begin
                n_vec++;
                if (bus.out_sum !== es[nout] || bus.out_cout !== ec[nout]) begin
                    n_err++;
                    $display("FAIL b2b_beat%0d: got %h cout=%b expected %h cout=%b",
                             nout, bus.out_sum, bus.out_cout, es[nout], ec[nout]);
                end
                nout++;
            end
            if (bus.in_valid && bus.in_ready === 1'b1) nin++;
            tick();
            cyc++;
        end
        bus.in_valid = 0;
        bus.out_ready = 1;
        n_vec++;
        if (nout != 8) begin
            n_err++;
            $display("FAIL b2b_timeout: got %0d results expected 8", nout);
        end
        repeat (6) tick();
        n_vec++;
        if (bus.out_valid !== 1'b0) begin
            n_err++;
            $display("FAIL b2b_extra: out_valid got %b expected 0", bus.out_valid);
        end
    endtask

    task automatic test_reset_flush();
        logic ghost = 1'b0;
        bus.out_ready = 1;
        for (int i = 0; i < 3; i++) begin
            bus.in_valid = 1; bus.in_a = 32'(i + 1); bus.in_b = 32'd1; bus.in_cin = 0; bus.in_sub = 0;
            tick();
        end
        bus.in_valid = 0;
        rst = 1'b1;
        #1;
        n_vec++;
        if (bus.in_ready !== 1'b0) begin
            n_err++;
            $display("FAIL flush_in_ready: got %b expected 0", bus.in_ready);
        end
        tick();
        rst = 1'b0;
        n_vec++;
        if (bus.out_valid !== 1'b0 || bus.out_sum !== 32'h0) begin
            n_err++;
            $display("FAIL flush_out: got v=%b %h expected v=0 00000000", bus.out_valid, bus.out_sum);
        end
        repeat (8) begin
            tick();
            if (bus.out_valid !== 1'b0) ghost = 1'b1;
        end
        n_vec++;
        if (ghost !== 1'b0) begin
            n_err++;
            $display("FAIL flush_ghost: got a result after reset expected none");
        end
        bus.in_valid = 1; bus.in_a = 32'hDEAD_BEEF; bus.in_b = 32'h1111_1111; bus.in_cin = 0; bus.in_sub = 0;
        tick();
        bus.in_valid = 0;
        repeat (4) tick();
        n_vec++;
        if (bus.out_valid !== 1'b1 || bus.out_sum !== 32'hEFBE_D000
            || {bus.out_cout, bus.out_ovf, bus.out_zero, bus.out_neg} !== 4'b0001) begin
            n_err++;
            $display("FAIL flush_new: got v=%b %h flags=%b%b%b%b expected v=1 efbed000 flags=0001",
                     bus.out_valid, bus.out_sum, bus.out_cout, bus.out_ovf, bus.out_zero, bus.out_neg);
        end
        tick();
    endtask

    task automatic test_width8();
        logic [7:0] va [2] = '{8'h0F, 8'h80};
        logic [7:0] vb [2] = '{8'h01, 8'h01};
        logic       vc [2] = '{1'b1, 1'b0};
        logic       vs [2] = '{1'b0, 1'b1};
        logic [7:0] es [2] = '{8'h11, 8'h7F};
        logic [3:0] ef [2] = '{4'b0000, 4'b1100};
        for (int i = 0; i < 2; i++) begin
            bus8.in_valid = 1; bus8.in_a = va[i]; bus8.in_b = vb[i]; bus8.in_cin = vc[i]; bus8.in_sub = vs[i];
            tick();
            bus8.in_valid = 0;
            n_vec++;
            if (bus8.out_valid !== 1'b0) begin
                n_err++;
                $display("FAIL w8_%0d_early: out_valid got %b expected 0", i, bus8.out_valid);
            end
            tick();
            n_vec++;
            if (bus8.out_valid !== 1'b1 || bus8.out_sum !== es[i]
                || {bus8.out_cout, bus8.out_ovf, bus8.out_zero, bus8.out_neg} !== ef[i]) begin
                n_err++;
                $display("FAIL w8_%0d: got v=%b %h flags=%b%b%b%b expected v=1 %h flags=%b", i,
                         bus8.out_valid, bus8.out_sum, bus8.out_cout, bus8.out_ovf,
                         bus8.out_zero, bus8.out_neg, es[i], ef[i]);
            end
            tick();
        end
    endtask

    initial begin
        test_reset();
        test_add();
        test_sub();
        test_back_to_back();
        test_reset_flush();
        test_width8();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule

// File: doc/pipelined_cla_adder.md
PIPELINED_CLA_ADDER -- requirements
Module: pipelined_cla_adder

Interface
REQ-001 SHALL have parameter WIDTH, default 32: operand/result width in bits.
REQ-002 SHALL have parameter STAGES, default 4: pipeline depth; each stage adds one SLICE = WIDTH/STAGES bits.
REQ-003 SHALL have clk  input  1  single clock; all state updates on rising edge.
REQ-004 SHALL have rst  input  1  reset, synchronous and active-high.
REQ-005 SHALL have in_valid  input  1  operand beat offered.
REQ-006 SHALL have in_ready  output  1  operand beat accepted when in_valid && in_ready at an edge.
REQ-007 SHALL have in_a, in_b  input  WIDTH  operands.
REQ-008 SHALL have in_cin  input  1  carry-in for add mode; ignored in subtract mode.
REQ-009 SHALL have in_sub  input  1  0 = a+b+cin, 1 = a-b.
REQ-010 SHALL have out_valid  output  1  result beat present.
REQ-011 SHALL have out_ready  input  1  consumer accepts result when out_valid && out_ready at an edge.
REQ-012 SHALL have out_sum  output  WIDTH  result.
REQ-013 SHALL have out_cout, out_ovf, out_zero, out_neg  output  1 each  carry-out, signed overflow, sum==0, sum MSB.

Function
REQ-014 SHALL reject at elaboration any WIDTH not divisible by STAGES, or SLICE not a multiple of 4.
REQ-015 SHALL compute subtract as a + ~b + 1; out_cout in subtract mode = 1 when a >= b unsigned (no borrow).
REQ-016 Stage k SHALL add operand bits [k*SLICE +: SLICE] using the carry registered by stage k-1 (stage 0 uses effective carry-in); unconsumed upper operand bits and completed lower sum bits SHALL travel with the beat in pipeline registers.
REQ-017 Within a stage, carries SHALL be produced by 4-bit generate/propagate lookahead groups (G=a&b, P=a|b) rippled group-to-group.
REQ-018 out_ovf SHALL equal carry into MSB XOR carry out of MSB; out_zero and out_neg SHALL be computed over the complete WIDTH-bit sum.
REQ-019 Latency SHALL be exactly STAGES cycles: a beat accepted at edge N appears with out_valid=1 after edge N+STAGES when no stall occurs.
REQ-020 Throughput SHALL be one beat per cycle while out_ready=1; each stage SHALL carry its own valid bit, bubbles propagate as invalid.
REQ-021 Global advance enable SHALL be en = !out_valid || out_ready; when en=0 every stage register (data and valid) SHALL hold.
REQ-022 in_ready SHALL equal en while rst=0, and SHALL be 0 while rst=1.
REQ-023 out_* data SHALL remain stable while out_valid=1 and out_ready=0.
REQ-024 Results SHALL leave in acceptance order; no beat SHALL be dropped or duplicated under any in_valid/out_ready pattern.
REQ-025 Simultaneous accept at input and release at output in one cycle SHALL both occur.

Reset
REQ-026 rst=1 at an edge SHALL clear every stage valid bit; next cycle out_valid=0, out_sum=0, all flags 0.
REQ-027 Reset mid-operation SHALL discard all in-flight beats; none SHALL appear at the output after reset.
REQ-028 Data registers other than outputs need not be cleared; first acceptance possible at first edge with rst=0.

Structure
REQ-029 A shared package SHALL hold default WIDTH/STAGES constants and the stage-register struct type (valid, partial sum, remaining a/b, carry, sub flag).
REQ-030 One sub-module, cla_slice (parametrised width, 4-bit lookahead groups, cin -> sum, cout, carry into MSB), SHALL be instantiated once per stage.

Verification
REQ-031 WIDTH=32, STAGES=4: add 0xFFFFFFFF+0x00000001, cin=0 -> sum 0x00000000, cout=1, zero=1, ovf=0, exactly 4 cycles after acceptance.
REQ-032 add 0x7FFFFFFF+0x00000001 -> sum 0x80000000, ovf=1, neg=1, cout=0.
REQ-033 sub 0x00000005-0x00000007 -> sum 0xFFFFFFFE, cout=0, neg=1, ovf=0; sub 7-5 -> 0x00000002, cout=1.
REQ-034 8 back-to-back beats, out_ready=0 for 3 cycles starting at cycle 6 -> in_ready=0 and outputs held during stall, all 8 results correct and in order.
REQ-035 rst pulsed 1 cycle with 3 beats in flight -> out_valid=0 next cycle, none of the 3 results ever emitted; new beat afterwards correct.
REQ-036 WIDTH=8, STAGES=1: 0x0F+0x01, cin=1 -> sum 0x11, cout=0, after 1 cycle.
